// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core load/store port and the loader/DMA port.
// Build option: define DMEM_ARB_CORE_PRIO_EN for fixed core priority (no loader lock/burst logic).
module dmem_port_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_req_we,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_rdata,

  input  logic              ldr_req_valid,
  output logic              ldr_req_ready,
  input  logic              ldr_req_we,
  input  logic [ADDR_W-1:0] ldr_req_addr,
  input  logic [DATA_W-1:0] ldr_req_wdata,
  input  logic              ldr_req_lock,
  output logic              ldr_rsp_valid,
  output logic [DATA_W-1:0] ldr_rsp_rdata,

  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              dbg_locked
);

  // Handshake: a request transfers in the cycle where req_valid && req_ready; ready is a
  // combinational grant, never high without its valid, and at most one ready is high per cycle.
  logic grant_core;
  logic grant_ldr;
  logic accept;

  assign core_req_ready = grant_core;
  assign ldr_req_ready  = grant_ldr;
  assign accept         = grant_core | grant_ldr;

`ifdef DMEM_ARB_CORE_PRIO_EN

  localparam int unused_max_burst = MAX_BURST;
  logic unused_lock;
  assign unused_lock = ldr_req_lock;

  always_comb begin
    grant_core = core_req_valid;
    grant_ldr  = ldr_req_valid & ~core_req_valid;
  end

  assign dbg_locked = 1'b0;

`else

  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   burst_cnt;
  logic               last_grant_ldr;
  logic               burst_full;

  assign burst_full = (burst_cnt == CNT_W'(MAX_BURST));

  // Once the burst budget is spent, plain round-robin applies; last_grant is the loader
  // at that point, so a waiting core wins the tie.
  always_comb begin
    grant_core = 1'b0;
    grant_ldr  = 1'b0;
    if (state == ST_LOCK && !burst_full && ldr_req_valid) begin
      grant_ldr = 1'b1;
    end else if (core_req_valid && ldr_req_valid) begin
      grant_core = last_grant_ldr;
      grant_ldr  = ~last_grant_ldr;
    end else begin
      grant_core = core_req_valid;
      grant_ldr  = ldr_req_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_ARB;
      burst_cnt      <= '0;
      last_grant_ldr <= 1'b1;
    end else begin
      if (grant_core) begin
        last_grant_ldr <= 1'b0;
      end else if (grant_ldr) begin
        last_grant_ldr <= 1'b1;
      end

      if (grant_ldr && ldr_req_lock) begin
        state <= ST_LOCK;
        if (state == ST_LOCK && !burst_full) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= CNT_W'(1);
        end
      end else if (accept || (state == ST_LOCK && !ldr_req_valid)) begin
        state     <= ST_ARB;
        burst_cnt <= '0;
      end
    end
  end

  assign dbg_locked = (state == ST_LOCK);

`endif

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    sel_we    = ldr_req_we;
    sel_addr  = ldr_req_addr;
    sel_wdata = ldr_req_wdata;
    if (grant_core) begin
      sel_we    = core_req_we;
      sel_addr  = core_req_addr;
      sel_wdata = core_req_wdata;
    end
  end

  // Stage 1 mirrors the memory command and remembers which requester owns it.
  logic              s1_valid;
  logic              s1_core;
  logic [DATA_W-1:0] rsp_data;

  assign rsp_data = mem_we ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we         <= 1'b0;
      mem_re         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      s1_valid       <= 1'b0;
      s1_core        <= 1'b0;
      core_rsp_valid <= 1'b0;
      core_rsp_rdata <= '0;
      ldr_rsp_valid  <= 1'b0;
      ldr_rsp_rdata  <= '0;
    end else begin
      mem_we   <= accept & sel_we;
      mem_re   <= accept & ~sel_we;
      s1_valid <= accept;
      s1_core  <= grant_core;
      if (accept) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end

      core_rsp_valid <= s1_valid & s1_core;
      ldr_rsp_valid  <= s1_valid & ~s1_core;
      if (s1_valid) begin
        if (s1_core) begin
          core_rsp_rdata <= rsp_data;
        end else begin
          ldr_rsp_rdata <= rsp_data;
        end
      end
    end
  end

endmodule
